// File: rtl/div_issue_ctrl.sv
// Issue/sequencing control for the EX-stage iterative divider (B lane).
// Optional last-result reuse is built when DIV_REUSE_EN is defined.
module div_issue_ctrl #(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_div_req,
   input  logic        ex_div_sel,
   input  logic        ex_signed,
   input  logic [31:0] ex_x,
   input  logic [31:0] ex_y,
   input  logic        flush,
   input  logic        pipe_hold,
   output logic        core_start,
   output logic        core_abort,
   output logic [31:0] core_x,
   output logic [31:0] core_y,
   output logic        core_signed,
   input  logic        core_done,
   input  logic [31:0] core_quo,
   input  logic [31:0] core_rem,
   output logic        stall_div,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        err_timeout
);

   // state  | meaning
   // S_IDLE | no divide in flight; accepts requests
   // S_BUSY | core running, counting toward timeout
   // S_DONE | result presented to MEM until pipe_hold drops
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(DIV_CYCLES);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_x, r_y, r_result;
   logic             r_signed, r_sel, r_err;

   logic        w_idle, w_busy, w_done, w_req, w_special, w_hit;
   logic        w_start, w_tmo, w_core_ok;
   logic [31:0] w_spec_res, w_hit_data;

   assign w_idle    = (r_state == S_IDLE);
   assign w_busy    = (r_state == S_BUSY);
   assign w_done    = (r_state == S_DONE);
   assign w_req     = ex_div_req & ~flush & ~rst;
   assign w_special = (ex_y == 32'd0) |
                      (ex_signed & (ex_x == 32'h8000_0000) & (ex_y == 32'hFFFF_FFFF));

   // y==0 gives quo=0/rem=x; signed overflow gives quo=INT_MIN/rem=0
   always_comb begin
      w_spec_res = 32'd0;
      if (ex_y == 32'd0) w_spec_res = ex_div_sel ? ex_x : 32'd0;
      else               w_spec_res = ex_div_sel ? 32'd0 : 32'h8000_0000;
   end

`ifdef DIV_REUSE_EN
   logic [31:0] r_rx, r_ry, r_rquo, r_rrem;
   logic        r_rsgn, r_rvld;

   assign w_hit      = w_idle & w_req & r_rvld & (ex_x == r_rx) & (ex_y == r_ry) &
                       (ex_signed == r_rsgn);
   assign w_hit_data = ex_div_sel ? r_rrem : r_rquo;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx   <= '0;
         r_ry   <= '0;
         r_rquo <= '0;
         r_rrem <= '0;
         r_rsgn <= 1'b0;
         r_rvld <= 1'b0;
      end else if (w_core_ok) begin
         r_rx   <= r_x;
         r_ry   <= r_y;
         r_rsgn <= r_signed;
         r_rquo <= core_quo;
         r_rrem <= core_rem;
         r_rvld <= 1'b1;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = 32'd0;
`endif

   assign w_start   = w_idle & w_req & ~w_special & ~w_hit;
   assign w_core_ok = w_busy & ~flush & core_done;
   assign w_tmo     = w_busy & ~flush & ~core_done & (r_cnt == LP_TMO);

   assign core_start  = w_start;
   assign core_abort  = w_busy & ~rst & (flush | w_tmo);
   assign core_x      = w_start ? ex_x : r_x;
   assign core_y      = w_start ? ex_y : r_y;
   assign core_signed = w_start ? ex_signed : r_signed;
   assign stall_div   = ~rst & ((w_idle & w_req & ~w_hit) | (w_busy & ~flush));
   assign res_valid   = (w_done & ~rst) | w_hit;
   assign res_data    = w_hit ? w_hit_data : (w_done & ~rst) ? r_result : 32'd0;
   assign err_timeout = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_signed <= 1'b0;
         r_sel    <= 1'b0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_req && !w_hit) begin
                  if (w_special) begin
                     r_result <= w_spec_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_x      <= ex_x;
                     r_y      <= ex_y;
                     r_signed <= ex_signed;
                     r_sel    <= ex_div_sel;
                     r_cnt    <= CNT_W'(1);
                     r_state  <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (flush) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else if (core_done) begin
                  r_result <= r_sel ? core_rem : core_quo;
                  r_cnt    <= '0;
                  r_state  <= S_DONE;
               end else if (r_cnt == LP_TMO) begin
                  r_err    <= 1'b1;
                  r_result <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               r_cnt <= '0;
               if (flush || !pipe_hold) r_state <= S_IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench plays the divider core.
module tb_div_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst, ex_div_req, ex_div_sel, ex_signed, flush, pipe_hold;
   logic [31:0] ex_x, ex_y;
   logic        core_start, core_abort, core_signed, core_done;
   logic [31:0] core_x, core_y, core_quo, core_rem;
   logic        stall_div, res_valid, err_timeout;
   logic [31:0] res_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_issue_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .ex_div_req(ex_div_req), .ex_div_sel(ex_div_sel), .ex_signed(ex_signed),
      .ex_x(ex_x), .ex_y(ex_y), .flush(flush), .pipe_hold(pipe_hold),
      .core_start(core_start), .core_abort(core_abort),
      .core_x(core_x), .core_y(core_y), .core_signed(core_signed),
      .core_done(core_done), .core_quo(core_quo), .core_rem(core_rem),
      .stall_div(stall_div), .res_valid(res_valid), .res_data(res_data),
      .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request; core answers lat cycles after core_start (lat=0: never).
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                        input logic sel, input int lat, input logic [31:0] quo,
                        input logic [31:0] rem, input int hold,
                        output int stall_n, output int starts, output int aborts,
                        output int valid_n, output logic [31:0] res, output logic stable);
      int start_cyc;
      int hold_left;
      logic got;
      start_cyc = -1;
      hold_left = hold;
      got = 1'b0;
      stall_n = 0; starts = 0; aborts = 0; valid_n = 0; res = '0; stable = 1'b1;
      step();
      ex_div_req = 1'b1; ex_x = x; ex_y = y; ex_signed = sgn; ex_div_sel = sel;
      core_done = 1'b0; core_quo = quo; core_rem = rem; pipe_hold = (hold > 0);
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         if (stall_div) stall_n++;
         if (core_start) begin
            starts++;
            if (start_cyc < 0) start_cyc = cyc;
         end
         if (core_abort) aborts++;
         if (res_valid) begin
            if (!got) res = res_data;
            else if (res_data !== res) stable = 1'b0;
            got = 1'b1;
            valid_n++;
            if (hold_left == 0) break;
            hold_left--;
         end
         step();
         core_done = (lat > 0) && (start_cyc >= 0) && (cyc + 1 == start_cyc + lat);
         pipe_hold = (hold_left > 0);
      end
      chk("op_completes", 32'(got), 32'd1);
      step();
      ex_div_req = 1'b0; pipe_hold = 1'b0; core_done = 1'b0;
      @(negedge clk);
      chk("op_back_idle", 32'(res_valid), 32'd0);
   endtask

   int st, ns, na, nv;
   logic [31:0] r;
   logic stb;

   initial begin
      rst = 1'b1; ex_div_req = 1'b1; ex_div_sel = 1'b0; ex_signed = 1'b0; flush = 1'b0;
      pipe_hold = 1'b0; ex_x = 32'd100; ex_y = 32'd7; core_done = 1'b0;
      core_quo = '0; core_rem = '0;
      step(); step();
      @(negedge clk);
      chk("rst_stall", 32'(stall_div), 32'd0);
      chk("rst_start", 32'(core_start), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      step();
      rst = 1'b0; ex_div_req = 1'b0;
      @(negedge clk);
      chk("idle_err", 32'(err_timeout), 32'd0);
      chk("idle_data", res_data, 32'd0);
      chk("idle_corex", core_x, 32'd0);

      // signed 100/7 quotient, core latency 33 (coincides with the timeout bound)
      do_op(32'd100, 32'd7, 1'b1, 1'b0, 33, 32'd14, 32'd2, 0, st, ns, na, nv, r, stb);
      chk("div_starts", 32'(ns), 32'd1);
      chk("div_stall", 32'(st), 32'd34);
      chk("div_valid_n", 32'(nv), 32'd1);
      chk("div_res", r, 32'd14);
      chk("div_no_abort", 32'(na), 32'd0);
      chk("div_done_wins", 32'(err_timeout), 32'd0);

      // signed overflow and divide-by-zero resolved locally
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5, 32'hDEAD, 32'hBEEF, 0, st, ns, na, nv, r, stb);
      chk("ovf_rem_starts", 32'(ns), 32'd0);
      chk("ovf_rem_stall", 32'(st), 32'd1);
      chk("ovf_rem_res", r, 32'd0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5, 32'hDEAD, 32'hBEEF, 0, st, ns, na, nv, r, stb);
      chk("ovf_quo_res", r, 32'h8000_0000);
      do_op(32'd5, 32'd0, 1'b0, 1'b1, 5, 32'hDEAD, 32'hBEEF, 0, st, ns, na, nv, r, stb);
      chk("dz_rem_res", r, 32'd5);
      chk("dz_rem_stall", 32'(st), 32'd1);
      chk("dz_rem_starts", 32'(ns), 32'd0);
      do_op(32'd5, 32'd0, 1'b0, 1'b0, 5, 32'hDEAD, 32'hBEEF, 0, st, ns, na, nv, r, stb);
      chk("dz_quo_res", r, 32'd0);

      // flush while idle with a request: no stall, no start
      step();
      ex_div_req = 1'b1; flush = 1'b1; ex_x = 32'd9; ex_y = 32'd3;
      @(negedge clk);
      chk("fl_idle_stall", 32'(stall_div), 32'd0);
      chk("fl_idle_start", 32'(core_start), 32'd0);
      step();
      flush = 1'b0; ex_div_req = 1'b0;
      @(negedge clk);
      chk("fl_idle_valid", 32'(res_valid), 32'd0);

      // flush at BUSY cycle 10, with a core_done arriving in the flush cycle
      step();
      ex_div_req = 1'b1; ex_x = 32'd77; ex_y = 32'd5; ex_signed = 1'b0; ex_div_sel = 1'b0;
      @(negedge clk);
      chk("fl_start", 32'(core_start), 32'd1);
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 10) begin
            flush = 1'b1; core_done = 1'b1; core_quo = 32'd99;
         end
         @(negedge clk);
         if (i == 5) begin
            chk("fl_latched_x", core_x, 32'd77);
            chk("fl_latched_y", core_y, 32'd5);
            chk("fl_busy_stall", 32'(stall_div), 32'd1);
         end
      end
      chk("fl_abort", 32'(core_abort), 32'd1);
      chk("fl_stall", 32'(stall_div), 32'd0);
      chk("fl_no_start", 32'(core_start), 32'd0);
      step();
      flush = 1'b0; core_done = 1'b0; ex_div_req = 1'b0;
      @(negedge clk);
      chk("fl_after_valid", 32'(res_valid), 32'd0);
      chk("fl_after_abort", 32'(core_abort), 32'd0);
      step();
      core_done = 1'b1;
      @(negedge clk);
      chk("fl_late_done", 32'(res_valid), 32'd0);
      step();
      core_done = 1'b0;
      @(negedge clk);
      chk("fl_late_done2", 32'(res_valid), 32'd0);

      // reset in the middle of BUSY: no abort pulse
      step();
      ex_div_req = 1'b1; ex_x = 32'd200; ex_y = 32'd9;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1; ex_div_req = 1'b0;
      @(negedge clk);
      chk("rstb_abort", 32'(core_abort), 32'd0);
      chk("rstb_stall", 32'(stall_div), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rstb_valid", 32'(res_valid), 32'd0);
      chk("rstb_idle_stall", 32'(stall_div), 32'd0);

      // downstream hold for 3 cycles while the result is presented
      do_op(32'd50, 32'd6, 1'b0, 1'b0, 3, 32'd8, 32'd2, 3, st, ns, na, nv, r, stb);
      chk("hold_valid_n", 32'(nv), 32'd4);
      chk("hold_stable", 32'(stb), 32'd1);
      chk("hold_res", r, 32'd8);
      chk("hold_starts", 32'(ns), 32'd1);
      chk("hold_stall", 32'(st), 32'd4);

      // core never answers
      do_op(32'd123, 32'd4, 1'b0, 1'b0, 0, 32'd30, 32'd3, 0, st, ns, na, nv, r, stb);
      chk("tmo_err", 32'(err_timeout), 32'd1);
      chk("tmo_res", r, 32'd0);
      chk("tmo_abort", 32'(na), 32'd1);
      chk("tmo_stall", 32'(st), 32'd34);
      do_op(32'd1000, 32'd10, 1'b0, 1'b0, 5, 32'd100, 32'd0, 0, st, ns, na, nv, r, stb);
      chk("post_tmo_res", r, 32'd100);
      chk("post_tmo_stall", 32'(st), 32'd6);
      chk("tmo_sticky", 32'(err_timeout), 32'd1);

      // DIV then MOD on the same operands
      do_op(32'd100, 32'd7, 1'b1, 1'b0, 4, 32'd14, 32'd2, 0, st, ns, na, nv, r, stb);
      chk("pair_div_res", r, 32'd14);
      chk("pair_div_stall", 32'(st), 32'd5);
`ifdef DIV_REUSE_EN
      do_op(32'd100, 32'd7, 1'b1, 1'b1, 4, 32'hDEAD, 32'hBEEF, 0, st, ns, na, nv, r, stb);
      chk("reuse_res", r, 32'd2);
      chk("reuse_stall", 32'(st), 32'd0);
      chk("reuse_starts", 32'(ns), 32'd0);
`else
      do_op(32'd100, 32'd7, 1'b1, 1'b1, 4, 32'd14, 32'd2, 0, st, ns, na, nv, r, stb);
      chk("mod_res", r, 32'd2);
      chk("mod_stall", 32'(st), 32'd5);
      chk("mod_starts", 32'(ns), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencer for the iterative divider in the EX stage of the dual-issue pipe.
- Accepts DIV/MOD requests from the B lane and latches operands.
- Starts and aborts the divider core, raises stall_div while a result is pending, and presents the selected quotient or remainder for the MEM pipeline register.
- Resolves divide-by-zero and signed overflow locally without using the core.

Parameters:
- DIV_CYCLES, 33, maximum core latency in cycles after core_start; also the timeout bound.
- CNT_W, 6, width of the busy counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_div_req  in  1  B-lane EX instruction is DIV/MOD; held high until the instruction leaves EX
- ex_div_sel  in  1  0 = quotient, 1 = remainder
- ex_signed  in  1  1 = signed operation
- ex_x  in  32  dividend (forwarded)
- ex_y  in  32  divisor (forwarded)
- flush  in  1  branch-correction flush of EX
- pipe_hold  in  1  downstream stall (dcache); EX must not advance
- core_start  out  1  one-cycle start pulse to the divider core
- core_abort  out  1  one-cycle abort pulse to the divider core
- core_x  out  32  latched dividend
- core_y  out  32  latched divisor
- core_signed  out  1  latched sign mode
- core_done  in  1  core result valid (single-cycle pulse)
- core_quo  in  32  core quotient
- core_rem  in  32  core remainder
- stall_div  out  1  freeze IF..EX
- res_valid  out  1  res_data is valid for the EX instruction this cycle
- res_data  out  32  selected result
- err_timeout  out  1  sticky: core missed DIV_CYCLES

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0.
  - Latches, result register and err_timeout cleared.
  - All outputs are 0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - If ex_div_req & ~flush and the request is special, the result is computed into the result register and the next state is DONE.
  - Special case y==0: quo=0, rem=x.
  - Special case signed, x==0x80000000 and y==0xFFFFFFFF: quo=0x80000000, rem=0.
  - For any other request, operands are latched, core_start is pulsed in this same cycle (core_x/core_y driven combinationally from ex_x/ex_y) and the next state is BUSY.
- BUSY:
  - cnt increments each cycle.
  - On core_done: latch the core_quo/core_rem selected by the latched ex_div_sel, then go to DONE.
  - If cnt==DIV_CYCLES with no done: set err_timeout, result=0, pulse core_abort, go to DONE.
- DONE:
  - res_valid=1 and res_data=result.
  - If pipe_hold, stay in DONE (result held stable).
  - Otherwise go to IDLE next cycle; ex_div_req still high in this cycle must not restart the core.
- stall_div = (IDLE & ex_div_req & ~flush) | BUSY. It is 0 in DONE.
  - Minimum stall is 1 cycle for special cases.
  - Core path stall is 1 + core latency.
- flush in any state:
  - Next state is IDLE and cnt=0.
  - core_abort is pulsed if the state was BUSY.
  - stall_div=0 in that cycle.
  - A core_done arriving in the flush cycle is ignored.
- Same-cycle core_done and cnt==DIV_CYCLES: core_done wins and err_timeout is not set.
- core_start and core_abort are never high in the same cycle.
- rst mid-BUSY: return to IDLE with no abort pulse; the core is reset by the same rst.
- core_x, core_y and core_signed come from the latched registers outside the start cycle.

Optional Feature:
- Macro: DIV_REUSE_EN.
- When defined:
  - Keep the last completed core operation (x, y, signed, quo, rem, valid bit).
  - An IDLE request whose x, y and signed match a valid entry is a hit. On a hit, res_valid=1 combinationally in the same cycle, stall_div=0, the state stays IDLE and the core is not started (covers a DIV followed by MOD).
  - The entry is cleared only by rst and updated only on core_done.
  - Special-case and timeout results are not stored.
- When undefined: no reuse storage; every non-special request uses the core.

Test Plan:
- rst, then signed x=100 y=7 sel=0, core done at 33 → core_start once, stall_div high 34 cycles, res_data=14 for 1 cycle.
- x=0x80000000 y=0xFFFFFFFF signed sel=1 → no core_start, stall_div 1 cycle, next cycle res_data=0 valid; y=0 sel=1 x=5 → res_data=5.
- Request accepted; flush at BUSY cycle 10 → core_abort pulse, IDLE next cycle, stall_div=0; later core_done ignored.
- core_done never asserted → err_timeout=1 after 33 BUSY cycles, res_data=0, core_abort pulse; new request still served.
- DONE with pipe_hold high 3 cycles → res_valid and res_data stable 4 cycles, no second core_start.
- DIV_REUSE_EN: DIV 100/7 then MOD 100/7 → second gives res_data=2 with zero stall and no core_start.
